// File: rtl/life_display_pipe.sv
// Game-of-Life cell renderer: maps VGA pixels to cell RAM addresses, colours by {was,is} state.
// Optional grid-line overlay is compiled in when GRID_LINES_EN is defined.
module life_display_pipe #(
  parameter int          CELL_LOG2 = 7,
  parameter int          COLS_LOG2 = 3,
  parameter int          ROWS_LOG2 = 3,
  parameter logic [11:0] C_DEAD    = 12'h000,
  parameter logic [11:0] C_BORN    = 12'hFF0,
  parameter logic [11:0] C_DIED    = 12'hF00,
`ifdef GRID_LINES_EN
  parameter logic [11:0] C_GRID    = 12'h333,
`endif
  parameter logic [11:0] C_ALIVE   = 12'h0F0
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic [10:0]                    x,
  input  logic [10:0]                    y,
  input  logic                           de_in,
  input  logic                           hs_in,
  input  logic                           vs_in,
  output logic [ROWS_LOG2+COLS_LOG2:0]   rd_addr_cur,
  output logic [ROWS_LOG2+COLS_LOG2:0]   rd_addr_prev,
  input  logic                           rd_cur,
  input  logic                           rd_prev,
  input  logic                           swap_req,
  output logic                           swap_ack,
  output logic                           bank_sel,
  output logic [11:0]                    rgb,
  output logic                           de_out,
  output logic                           hs_out,
  output logic                           vs_out
);

  localparam logic [31:0] X_LIM = 32'd1 << (CELL_LOG2 + COLS_LOG2);
  localparam logic [31:0] Y_LIM = 32'd1 << (CELL_LOG2 + ROWS_LOG2);

  logic [COLS_LOG2-1:0] w_col;
  logic [ROWS_LOG2-1:0] w_row;
  logic                 w_oor;
  logic                 w_vs_rise;
  logic                 w_swap;
  logic [11:0]          w_rgb_next;

  logic r_bank, r_pending, r_ack;
  logic r_oor1, r_de1, r_hs1, r_vs1;
  logic r_oor2, r_de2, r_hs2, r_vs2;
  logic r_de3, r_hs3, r_vs3;
  logic [11:0] r_rgb;
  logic [ROWS_LOG2+COLS_LOG2:0] r_addr_cur, r_addr_prev;

  assign w_col = x[CELL_LOG2 +: COLS_LOG2];
  assign w_row = y[CELL_LOG2 +: ROWS_LOG2];
  assign w_oor = ({21'd0, x} >= X_LIM) || ({21'd0, y} >= Y_LIM);

  // r_vs1 is vs_in one clock old, so this is the first clock vs_in is seen high
  assign w_vs_rise = vs_in && !r_vs1;
  assign w_swap    = w_vs_rise && (r_pending || swap_req);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_bank    <= 1'b0;
      r_pending <= 1'b0;
      r_ack     <= 1'b0;
    end else begin
      r_ack <= w_swap;
      if (w_swap) begin
        r_bank    <= ~r_bank;
        r_pending <= 1'b0;
      end else begin
        r_pending <= r_pending || swap_req;
      end
    end
  end

`ifdef GRID_LINES_EN
  logic r_grid1, r_grid2;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_grid1 <= 1'b0;
      r_grid2 <= 1'b0;
    end else begin
      r_grid1 <= (x[CELL_LOG2-1:0] == '0) || (y[CELL_LOG2-1:0] == '0);
      r_grid2 <= r_grid1;
    end
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_addr_cur  <= '0;
      r_addr_prev <= {1'b1, {(ROWS_LOG2+COLS_LOG2){1'b0}}};
      {r_oor1, r_de1, r_hs1, r_vs1} <= '0;
      {r_oor2, r_de2, r_hs2, r_vs2} <= '0;
      {r_de3, r_hs3, r_vs3}         <= '0;
      r_rgb <= '0;
    end else begin
      r_addr_cur  <= {r_bank, w_row, w_col};
      r_addr_prev <= {~r_bank, w_row, w_col};
      {r_oor1, r_de1, r_hs1, r_vs1} <= {w_oor, de_in, hs_in, vs_in};
      {r_oor2, r_de2, r_hs2, r_vs2} <= {r_oor1, r_de1, r_hs1, r_vs1};
      {r_de3, r_hs3, r_vs3}         <= {r_de2, r_hs2, r_vs2};
      r_rgb <= w_rgb_next;
    end
  end

  // RAM data arrives alongside the stage-2 side-band bits
  always_comb begin
    w_rgb_next = '0;
    if (r_de2 && !r_oor2) begin
      case ({rd_prev, rd_cur})
        2'b00:   w_rgb_next = C_DEAD;
        2'b01:   w_rgb_next = C_BORN;
        2'b10:   w_rgb_next = C_DIED;
        default: w_rgb_next = C_ALIVE;
      endcase
`ifdef GRID_LINES_EN
      if (r_grid2) w_rgb_next = C_GRID;
`endif
    end
  end

  assign rd_addr_cur  = r_addr_cur;
  assign rd_addr_prev = r_addr_prev;
  assign swap_ack     = r_ack;
  assign bank_sel     = r_bank;
  assign rgb          = r_rgb;
  assign de_out       = r_de3;
  assign hs_out       = r_hs3;
  assign vs_out       = r_vs3;

endmodule

// File: tb/tb_life_display_pipe.sv
// Directed bench for life_display_pipe: reset, colour map, range masking, latency, bank swap.
module tb_life_display_pipe;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [10:0] x, y;
  logic        de_in, hs_in, vs_in;
  logic [6:0]  rd_addr_cur, rd_addr_prev;
  logic        rd_cur, rd_prev;
  logic        swap_req, swap_ack, bank_sel;
  logic [11:0] rgb;
  logic        de_out, hs_out, vs_out;

  logic mem [0:127];
  int   n_tot = 0;
  int   n_bad = 0;

  always #5 clk = ~clk;

  life_display_pipe dut (
    .clk(clk), .rst_n(rst_n), .x(x), .y(y), .de_in(de_in), .hs_in(hs_in), .vs_in(vs_in),
    .rd_addr_cur(rd_addr_cur), .rd_addr_prev(rd_addr_prev), .rd_cur(rd_cur), .rd_prev(rd_prev),
    .swap_req(swap_req), .swap_ack(swap_ack), .bank_sel(bank_sel), .rgb(rgb),
    .de_out(de_out), .hs_out(hs_out), .vs_out(vs_out)
  );

  // sync-read cell RAM covering both banks
  always @(posedge clk) begin
    rd_cur  <= mem[rd_addr_cur];
    rd_prev <= mem[rd_addr_prev];
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tot++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic pix(input string tag, input int px, input int py, input logic de,
                     input logic [6:0] exp_addr, input logic [11:0] exp_rgb);
    @(negedge clk);
    x = 11'(px); y = 11'(py); de_in = de;
    @(posedge clk); #1;
    chk({tag, "_addr"}, 32'(rd_addr_cur), 32'(exp_addr));
    repeat (2) @(posedge clk);
    #1;
    chk({tag, "_rgb"}, 32'(rgb), 32'(exp_rgb));
  endtask

  initial begin
    for (int i = 0; i < 128; i++) mem[i] = 1'b0;
    rst_n = 1'b0; x = 0; y = 0; de_in = 0; hs_in = 0; vs_in = 0; swap_req = 0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // stream active pixels then reset mid-frame
    mem[7'h01] = 1'b1;
    x = 11'd130; y = 11'd5; de_in = 1'b1; hs_in = 1'b1;
    repeat (5) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("rst_rgb", 32'(rgb), 0);
    chk("rst_de", 32'(de_out), 0);
    chk("rst_hs", 32'(hs_out), 0);
    chk("rst_acur", 32'(rd_addr_cur), 32'h00);
    chk("rst_aprev", 32'(rd_addr_prev), 32'h40);
    chk("rst_bank", 32'(bank_sel), 0);
    chk("rst_ack", 32'(swap_ack), 0);
    hs_in = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("lat_de_early", 32'(de_out), 0);
    @(posedge clk); #1;
    chk("lat_de", 32'(de_out), 1);
    chk("lat_rgb", 32'(rgb), 32'hFF0);

    // colour map
    pix("born", 130, 5, 1'b1, 7'h01, 12'hFF0);
    chk("born_prev_addr", 32'(rd_addr_prev), 32'h41);
    mem[7'h42] = 1'b1;
    pix("died", 260, 5, 1'b1, 7'h02, 12'hF00);
    mem[7'h0B] = 1'b1; mem[7'h4B] = 1'b1;
    pix("alive", 390, 130, 1'b1, 7'h0B, 12'h0F0);
    pix("dead", 600, 300, 1'b1, 7'h14, 12'h000);
    pix("de_off", 390, 130, 1'b0, 7'h0B, 12'h000);

    // range masking and wrap
    mem[7'h00] = 1'b1;
    pix("oor_x", 1024, 5, 1'b1, 7'h00, 12'h000);
    pix("oor_y", 130, 1030, 1'b1, 7'h01, 12'h000);
    mem[7'h3F] = 1'b1;
    pix("corner", 1023, 1023, 1'b1, 7'h3F, 12'hFF0);

`ifdef GRID_LINES_EN
    pix("grid", 256, 10, 1'b1, 7'h02, 12'h333);
`else
    pix("grid", 256, 10, 1'b1, 7'h02, 12'hF00);
`endif

    // hsync / vsync delay of 3
    @(negedge clk); hs_in = 1'b1;
    @(negedge clk); hs_in = 1'b0; vs_in = 1'b1;
    @(posedge clk); #1;
    chk("hs_d2", 32'(hs_out), 0);
    @(posedge clk); #1;
    chk("hs_d3", 32'(hs_out), 1);
    chk("vs_d2", 32'(vs_out), 0);
    @(posedge clk); #1;
    chk("vs_d3", 32'(vs_out), 1);
    chk("hs_d4", 32'(hs_out), 0);
    @(negedge clk); vs_in = 1'b0;
    repeat (4) @(negedge clk);

    // swap waits for a vsync rise
    x = 11'd130; y = 11'd100; de_in = 1'b1;
    swap_req = 1'b1;
    repeat (10) @(negedge clk);
    chk("swap_wait_bank", 32'(bank_sel), 0);
    chk("swap_wait_ack", 32'(swap_ack), 0);
    chk("swap_wait_addr", 32'(rd_addr_cur[6]), 0);
    vs_in = 1'b1;
    @(posedge clk); #1;
    chk("swap_bank", 32'(bank_sel), 1);
    chk("swap_ack", 32'(swap_ack), 1);
    @(negedge clk); swap_req = 1'b0;
    @(posedge clk); #1;
    chk("swap_ack_pulse", 32'(swap_ack), 0);
    chk("swap_addr_cur", 32'(rd_addr_cur), 32'h41);
    chk("swap_addr_prev", 32'(rd_addr_prev), 32'h01);

    // vsync rise without a request: no swap
    repeat (3) @(negedge clk);
    vs_in = 1'b0;
    repeat (3) @(negedge clk);
    vs_in = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("noreq_bank", 32'(bank_sel), 1);
    @(negedge clk); vs_in = 1'b0;
    repeat (2) @(negedge clk);

    // request and vsync rise in the same clock
    swap_req = 1'b1; vs_in = 1'b1;
    @(posedge clk); #1;
    chk("same_bank", 32'(bank_sel), 0);
    chk("same_ack", 32'(swap_ack), 1);
    @(negedge clk); swap_req = 1'b0;
    repeat (2) @(negedge clk);
    vs_in = 1'b0;
    repeat (2) @(negedge clk);

    // reset one clock after an ack
    swap_req = 1'b1;
    @(negedge clk); vs_in = 1'b1;
    @(posedge clk); #1;
    chk("pre_rst_bank", 32'(bank_sel), 1);
    @(negedge clk); swap_req = 1'b0;
    @(posedge clk);
    @(negedge clk); rst_n = 1'b0;
    #1;
    chk("ack_rst_bank", 32'(bank_sel), 0);
    chk("ack_rst_ack", 32'(swap_ack), 0);
    chk("ack_rst_rgb", 32'(rgb), 0);
    vs_in = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    repeat (2) @(negedge clk);
    vs_in = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_pend_clear", 32'(bank_sel), 0);

    $display("test done: total=%0d bad=%0d", n_tot, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1);
  end

endmodule
